// File: rtl/dma_channel_priority_arbiter.sv
// dma_channel_priority_arbiter
// Four-channel DMA request arbiter and channel-state keeper. Merges hardware
// DREQ lines with software requests, applies the channel mask, and picks one
// channel by fixed or rotating priority. The grant is held for a whole
// transfer cycle. Channels are auto-masked at terminal count unless they are
// set to auto-initialize.
//
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   DREQ, dreqSense   hardware requests and their polarity (1 = active-low)
//   dackSense         DACK polarity (0 = active-low, 1 = active-high)
//   rotatingPriority  0 = fixed (ch0 highest), 1 = rotating
//   dmaDisable        blocks new arbitration
//   autoInit          per-channel auto-initialize enable
//   maskWrite/Data    single-channel mask write ({value, channel})
//   maskAllWrite/Data whole mask vector write
//   swReqWrite/Data   software request set/clear ({value, channel})
//   assertDACK        DACK window from timing control
//   cycleDone         end-of-transfer-cycle pulse
//   tcReached         terminal count flag, qualifies cycleDone
//   reqValid, grantCh held grant to timing control
//   DACK              one-hot acknowledge of the granted channel
//   maskReg, swReqReg current mask and software request registers
module dma_channel_priority_arbiter #(
    parameter int unsigned NUM_CH = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [NUM_CH-1:0]         DREQ,
    input  logic                      dreqSense,
    input  logic                      dackSense,
    input  logic                      rotatingPriority,
    input  logic                      dmaDisable,
    input  logic [NUM_CH-1:0]         autoInit,
    input  logic                      maskWrite,
    input  logic [2:0]                maskData,
    input  logic                      maskAllWrite,
    input  logic [NUM_CH-1:0]         maskAllData,
    input  logic                      swReqWrite,
    input  logic [2:0]                swReqData,
    input  logic                      assertDACK,
    input  logic                      cycleDone,
    input  logic                      tcReached,
    output logic                      reqValid,
    output logic [$clog2(NUM_CH)-1:0] grantCh,
    output logic [NUM_CH-1:0]         DACK,
    output logic [NUM_CH-1:0]         maskReg,
    output logic [NUM_CH-1:0]         swReqReg
);

    localparam int unsigned CH_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANTED = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [NUM_CH-1:0]   r_mask;
    logic [NUM_CH-1:0]   r_swreq;
    logic [CH_W-1:0]     r_last;
    logic                r_req_valid;
    logic [CH_W-1:0]     r_grant_ch;
    logic [NUM_CH-1:0]   r_grant_oh;

    logic [NUM_CH-1:0]   w_req_hw;
    logic [NUM_CH-1:0]   w_eff_req;
    logic [CH_W-1:0]     w_start;
    logic [CH_W-1:0]     w_idx;
    logic [CH_W-1:0]     w_win;
    logic                w_found;
    logic                w_grant_en;
    logic                w_done;
    logic [NUM_CH-1:0]   w_mask_nxt;
    logic [NUM_CH-1:0]   w_swreq_nxt;
    logic [NUM_CH-1:0]   w_dack_act;

    // Request formation: normalise DREQ polarity, merge software requests, mask.
    assign w_req_hw  = DREQ ^ {NUM_CH{dreqSense}};
    assign w_eff_req = (w_req_hw | r_swreq) & ~r_mask;

    // Priority scan starting at the highest-priority channel; the index wraps
    // naturally because NUM_CH is a power of two.
    always_comb begin
        w_start = rotatingPriority ? (r_last + CH_W'(1)) : '0;
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_idx = w_start + CH_W'(i);
            if (!w_found && w_eff_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and transition strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found && !dmaDisable) begin
                    w_state_nxt = S_GRANTED;
                    w_grant_en  = 1'b1;
                end
            end
            S_GRANTED: begin
                if (cycleDone) begin
                    w_state_nxt = S_RELEASE;
                    w_done      = 1'b1;
                end
            end
            S_RELEASE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Mask and software-request updates: end-of-cycle effects first, explicit
    // register writes applied afterwards so they win on the same bit.
    always_comb begin
        w_mask_nxt  = r_mask;
        w_swreq_nxt = r_swreq;
        if (w_done) begin
            w_swreq_nxt[r_grant_ch] = 1'b0;
            if (tcReached && !autoInit[r_grant_ch]) begin
                w_mask_nxt[r_grant_ch] = 1'b1;
            end
        end
        if (maskAllWrite) begin
            w_mask_nxt = maskAllData;
        end
        if (maskWrite) begin
            w_mask_nxt[maskData[1:0]] = maskData[2];
        end
        if (swReqWrite) begin
            w_swreq_nxt[swReqData[1:0]] = swReqData[2];
        end
    end

    // Grant, service history and channel registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_mask      <= {NUM_CH{1'b1}};
            r_swreq     <= '0;
            r_last      <= CH_W'(NUM_CH - 1);
            r_req_valid <= 1'b0;
            r_grant_ch  <= '0;
            r_grant_oh  <= '0;
        end else begin
            r_mask  <= w_mask_nxt;
            r_swreq <= w_swreq_nxt;
            if (w_grant_en) begin
                r_req_valid <= 1'b1;
                r_grant_ch  <= w_win;
                r_grant_oh  <= NUM_CH'(1) << w_win;
            end
            if (w_done) begin
                r_req_valid <= 1'b0;
                r_last      <= r_grant_ch;
            end
        end
    end

    // DACK is qualified live by the timing-control window, then polarised.
    assign w_dack_act = ((r_state == S_GRANTED) && assertDACK) ? r_grant_oh : '0;
    assign DACK       = w_dack_act ^ {NUM_CH{~dackSense}};

    assign reqValid = r_req_valid;
    assign grantCh  = r_grant_ch;
    assign maskReg  = r_mask;
    assign swReqReg = r_swreq;

endmodule

// File: tb/tb_dma_channel_priority_arbiter.sv
// Self-checking bench for dma_channel_priority_arbiter: directed scenarios plus
// randomized traffic, all compared against a behavioural channel model.
module tb_dma_channel_priority_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] DREQ;
    logic       dreqSense, dackSense, rotatingPriority, dmaDisable;
    logic [3:0] autoInit;
    logic       maskWrite;
    logic [2:0] maskData;
    logic       maskAllWrite;
    logic [3:0] maskAllData;
    logic       swReqWrite;
    logic [2:0] swReqData;
    logic       assertDACK, cycleDone, tcReached;
    logic       reqValid;
    logic [1:0] grantCh;
    logic [3:0] DACK, maskReg, swReqReg;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: phase 0 = idle, 1 = granted, 2 = release.
    int         m_phase;
    logic [3:0] m_mask, m_sw;
    int         m_last, m_grant;
    logic       m_rv;

    dma_channel_priority_arbiter #(.NUM_CH(4)) dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .dreqSense(dreqSense),
        .dackSense(dackSense), .rotatingPriority(rotatingPriority),
        .dmaDisable(dmaDisable), .autoInit(autoInit),
        .maskWrite(maskWrite), .maskData(maskData),
        .maskAllWrite(maskAllWrite), .maskAllData(maskAllData),
        .swReqWrite(swReqWrite), .swReqData(swReqData),
        .assertDACK(assertDACK), .cycleDone(cycleDone), .tcReached(tcReached),
        .reqValid(reqValid), .grantCh(grantCh), .DACK(DACK),
        .maskReg(maskReg), .swReqReg(swReqReg)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_dack();
        logic [3:0] act;
        act = '0;
        if (m_phase == 1 && assertDACK) act[m_grant] = 1'b1;
        return dackSense ? act : ~act;
    endfunction

    // One clock of the model, using the inputs as seen on the rising edge.
    task automatic model_update();
        logic [3:0] req;
        bit         found;
        int         c;
        if (RESET) begin
            m_phase = 0; m_mask = 4'hF; m_sw = 4'h0; m_last = 3;
            m_grant = 0; m_rv = 1'b0;
            return;
        end
        req = ((DREQ ^ {4{dreqSense}}) | m_sw) & ~m_mask;
        case (m_phase)
            0: begin
                found = 0;
                for (int k = 0; k < 4; k++) begin
                    c = rotatingPriority ? (m_last + 1 + k) % 4 : k;
                    if (!found && req[c]) begin
                        found = 1;
                        m_grant = c;
                    end
                end
                if (found && !dmaDisable) begin
                    m_phase = 1;
                    m_rv = 1'b1;
                end
            end
            1: begin
                if (cycleDone) begin
                    m_last = m_grant;
                    m_sw[m_grant] = 1'b0;
                    if (tcReached && !autoInit[m_grant]) m_mask[m_grant] = 1'b1;
                    m_rv = 1'b0;
                    m_phase = 2;
                end
            end
            default: m_phase = 0;
        endcase
        if (maskAllWrite) m_mask = maskAllData;
        if (maskWrite) m_mask[maskData[1:0]] = maskData[2];
        if (swReqWrite) m_sw[swReqData[1:0]] = swReqData[2];
    endtask

    // Called just after a falling edge with inputs already driven; returns
    // just after the next falling edge with registered outputs checked.
    task automatic tick();
        #1;
        check("dack", DACK, model_dack());
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        check("req_valid", reqValid, m_rv);
        if (m_rv) check("grant_ch", grantCh, m_grant);
        check("mask_reg", maskReg, m_mask);
        check("swreq_reg", swReqReg, m_sw);
    endtask

    task automatic clear_strobes();
        maskWrite = 0; maskAllWrite = 0; swReqWrite = 0;
        cycleDone = 0; tcReached = 0; RESET = 0;
    endtask

    task automatic do_reset();
        clear_strobes();
        DREQ = 0; dreqSense = 0; dackSense = 0; rotatingPriority = 0;
        dmaDisable = 0; autoInit = 0; assertDACK = 0;
        maskData = 0; maskAllData = 0; swReqData = 0;
        RESET = 1;
        tick();
        RESET = 0;
        check("rst_dack", DACK, 4'hF);
    endtask

    task automatic unmask_all();
        maskAllWrite = 1; maskAllData = 4'h0;
        tick();
        maskAllWrite = 0;
    endtask

    initial begin
        m_phase = 0; m_mask = 4'hF; m_sw = 0; m_last = 3; m_grant = 0; m_rv = 0;
        @(negedge CLK);

        // Fixed priority, active-low DACK.
        do_reset();
        check("rst_mask", maskReg, 4'hF);
        check("rst_rv", reqValid, 1'b0);
        DREQ = 4'b1010;
        unmask_all();
        tick();
        check("t1_rv", reqValid, 1'b1);
        check("t1_grant", grantCh, 2'd1);
        assertDACK = 1;
        #1 check("t1_dack", DACK, 4'b1101);
        tick();
        assertDACK = 0;

        // Rotating order with one release cycle between grants.
        do_reset();
        rotatingPriority = 1; DREQ = 4'hF;
        unmask_all();
        tick();
        for (int g = 0; g < 5; g++) begin
            check("t2_grant", grantCh, 32'(g % 4));
            cycleDone = 1;
            tick();
            cycleDone = 0;
            tick();
            check("t2_release", reqValid, 1'b0);
            tick();
            check("t2_regrant", reqValid, 1'b1);
        end

        // Terminal-count auto-mask versus auto-initialize.
        do_reset();
        DREQ = 4'b0100;
        unmask_all();
        tick();
        check("t3_grant", grantCh, 2'd2);
        cycleDone = 1; tcReached = 1;
        tick();
        clear_strobes();
        check("t3_mask", maskReg, 4'b0100);
        tick(); tick(); tick();
        check("t3_no_grant", reqValid, 1'b0);
        autoInit = 4'b0100;
        unmask_all();
        tick();
        cycleDone = 1; tcReached = 1;
        tick();
        clear_strobes();
        check("t3_autoinit_mask", maskReg, 4'b0000);
        autoInit = 0;

        // Software requests and write-wins-over-clear.
        do_reset();
        unmask_all();
        swReqWrite = 1; swReqData = 3'b111;
        tick();
        swReqWrite = 0;
        tick();
        check("t4_grant", grantCh, 2'd3);
        cycleDone = 1;
        tick();
        cycleDone = 0;
        check("t4_sw_clr", swReqReg, 4'b0000);
        tick(); tick();
        swReqWrite = 1;
        tick();
        swReqWrite = 0;
        tick();
        cycleDone = 1; swReqWrite = 1;
        tick();
        clear_strobes();
        check("t4_sw_keep", swReqReg[3], 1'b1);

        // Inverted DREQ sense and active-high DACK.
        do_reset();
        dreqSense = 1; DREQ = 4'b1110;
        unmask_all();
        tick();
        check("t5_grant", grantCh, 2'd0);
        dackSense = 1; assertDACK = 1;
        #1 check("t5_dack_on", DACK, 4'b0001);
        tick();
        assertDACK = 0;
        #1 check("t5_dack_off", DACK, 4'b0000);
        tick();

        // Reset while granted.
        assertDACK = 1; dackSense = 0;
        RESET = 1;
        tick();
        RESET = 0;
        check("t6_rv", reqValid, 1'b0);
        check("t6_dack", DACK, 4'hF);
        check("t6_mask", maskReg, 4'hF);
        tick(); tick();
        check("t6_no_grant", reqValid, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            RESET            = ($urandom_range(0, 199) == 0);
            DREQ             = 4'($urandom);
            dreqSense        = ($urandom_range(0, 9) == 0);
            dackSense        = 1'($urandom);
            rotatingPriority = ($urandom_range(0, 3) != 0);
            dmaDisable       = ($urandom_range(0, 9) == 0);
            autoInit         = 4'($urandom);
            maskWrite        = ($urandom_range(0, 7) == 0);
            maskData         = 3'($urandom);
            maskAllWrite     = ($urandom_range(0, 9) == 0);
            maskAllData      = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            swReqWrite       = ($urandom_range(0, 7) == 0);
            swReqData        = 3'($urandom);
            assertDACK       = 1'($urandom);
            cycleDone        = ($urandom_range(0, 3) == 0);
            tcReached        = 1'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
